// File: rtl/hazard_pkg.sv
// Shared encodings, pipeline record type and lookup helpers for the hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TNEW_W = 2;
    localparam int unsigned FD_W   = 3;
    localparam int unsigned FE_W   = 2;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ALU  = 2'd1,
        CLS_LOAD = 2'd2,
        CLS_LINK = 2'd3
    } cls_e;

    localparam logic [FD_W-1:0] FD_RF    = 3'd0;
    localparam logic [FD_W-1:0] FD_W_DAT = 3'd1;
    localparam logic [FD_W-1:0] FD_ALU_M = 3'd2;
    localparam logic [FD_W-1:0] FD_PC8_M = 3'd3;
    localparam logic [FD_W-1:0] FD_PC8_E = 3'd4;

    localparam logic [FE_W-1:0] FE_OWN   = 2'd0;
    localparam logic [FE_W-1:0] FE_W_DAT = 2'd1;
    localparam logic [FE_W-1:0] FE_ALU_M = 2'd2;
    localparam logic [FE_W-1:0] FE_PC8_M = 2'd3;

    typedef struct packed {
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  wa;
        cls_e              cls;
        logic [TNEW_W-1:0] tnew;
    } rec_t;

    // Cycles until the result exists, measured from the E stage.
    function automatic logic [TNEW_W-1:0] tnew_of(input cls_e cls);
        case (cls)
            CLS_ALU:  return TNEW_W'(1);
            CLS_LOAD: return TNEW_W'(2);
            default:  return TNEW_W'(0);
        endcase
    endfunction

    // $0 and non-writing records never produce a match.
    function automatic logic hit(input rec_t r, input logic [REG_W-1:0] a);
        return (r.wa != '0) && (r.cls != CLS_NONE) && (r.wa == a);
    endfunction

    function automatic logic [FD_W-1:0] d_sel(input rec_t e, input rec_t m,
                                              input rec_t w, input logic [REG_W-1:0] a);
        if (hit(e, a)) begin
            return (e.cls == CLS_LINK && e.tnew == '0) ? FD_PC8_E : FD_RF;
        end else if (hit(m, a)) begin
            if (m.tnew != '0)         return FD_RF;
            else if (m.cls == CLS_ALU)  return FD_ALU_M;
            else if (m.cls == CLS_LINK) return FD_PC8_M;
            else                        return FD_RF;
        end else if (hit(w, a)) begin
            return FD_W_DAT;
        end
        return FD_RF;
    endfunction

    function automatic logic [FE_W-1:0] e_sel(input rec_t m, input rec_t w,
                                              input logic [REG_W-1:0] a);
        if (hit(m, a) && m.cls == CLS_ALU)       return FE_ALU_M;
        else if (hit(m, a) && m.cls == CLS_LINK) return FE_PC8_M;
        else if (hit(w, a))                      return FE_W_DAT;
        return FE_OWN;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline record register with bubble insertion and saturating tnew decrement.
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bubble,
    input  logic dec,
    input  rec_t d,
    output rec_t q
);

    rec_t nxt;

    always_comb begin
        nxt = d;
        if (dec && d.tnew != '0) begin
            nxt.tnew = d.tnew - TNEW_W'(1);
        end
        if (bubble) begin
            nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall detection, D/E/M forwarding selects, stall counter.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  rs_D,
    input  logic [REG_W-1:0]  rt_D,
    input  logic              rs_use_D,
    input  logic              rt_use_D,
    input  logic [1:0]        tuse_rs_D,
    input  logic [1:0]        tuse_rt_D,
    input  logic [REG_W-1:0]  wa_D,
    input  logic [1:0]        wcls_D,
    output logic [FD_W-1:0]   f_rs_d,
    output logic [FD_W-1:0]   f_rt_d,
    output logic [FE_W-1:0]   f_rs_e,
    output logic [FE_W-1:0]   f_rt_e,
    output logic              f_rt_m,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    rec_t d_rec;
    rec_t e_rec;
    rec_t m_rec;
    rec_t w_rec;

    always_comb begin
        d_rec      = '0;
        d_rec.rs   = rs_D;
        d_rec.rt   = rt_D;
        d_rec.wa   = wa_D;
        d_rec.cls  = cls_e'(wcls_D);
        d_rec.tnew = tnew_of(cls_e'(wcls_D));
    end

    hazard_stage_reg u_e (.clk(clk), .reset(reset), .bubble(stall), .dec(1'b0), .d(d_rec), .q(e_rec));
    hazard_stage_reg u_m (.clk(clk), .reset(reset), .bubble(1'b0),  .dec(1'b1), .d(e_rec), .q(m_rec));
    hazard_stage_reg u_w (.clk(clk), .reset(reset), .bubble(1'b0),  .dec(1'b1), .d(m_rec), .q(w_rec));

    // Both operands are OR-ed into one stall, so a double hazard costs a single cycle per cycle.
    always_comb begin
        stall = 1'b0;
        if (rs_use_D && ((hit(e_rec, rs_D) && e_rec.tnew > tuse_rs_D) ||
                         (hit(m_rec, rs_D) && m_rec.tnew > tuse_rs_D))) begin
            stall = 1'b1;
        end
        if (rt_use_D && ((hit(e_rec, rt_D) && e_rec.tnew > tuse_rt_D) ||
                         (hit(m_rec, rt_D) && m_rec.tnew > tuse_rt_D))) begin
            stall = 1'b1;
        end
    end

    always_comb begin
        f_rs_d = d_sel(e_rec, m_rec, w_rec, rs_D);
        f_rt_d = d_sel(e_rec, m_rec, w_rec, rt_D);
        f_rs_e = e_sel(m_rec, w_rec, e_rec.rs);
        f_rt_e = e_sel(m_rec, w_rec, e_rec.rt);
        f_rt_m = hit(w_rec, m_rec.rt);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Source fields of the older records are carried for completeness but not consulted.
    logic unused_fields;
    assign unused_fields = ^{m_rec.rs, w_rec.rs, w_rec.rt, w_rec.tnew};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instruction pairs with hand-computed stall/forward results.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_D, rt_D, wa_D;
    logic        rs_use_D, rt_use_D;
    logic [1:0]  tuse_rs_D, tuse_rt_D, wcls_D;
    logic [2:0]  f_rs_d, f_rt_d;
    logic [1:0]  f_rs_e, f_rt_e;
    logic        f_rt_m;
    logic        stall;
    logic [31:0] stall_cnt;

    int n_total = 0;
    int n_pass  = 0;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .rs_use_D(rs_use_D), .rt_use_D(rt_use_D),
        .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .wa_D(wa_D), .wcls_D(wcls_D),
        .f_rs_d(f_rs_d), .f_rt_d(f_rt_d), .f_rs_e(f_rs_e), .f_rt_e(f_rt_e),
        .f_rt_m(f_rt_m), .stall(stall), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        else n_pass++;
    endtask

    // Present a D-stage instruction and let combinational outputs settle.
    task automatic ins(input logic [4:0] rs, input logic ru, input logic [1:0] tr,
                       input logic [4:0] rt, input logic tu, input logic [1:0] tt,
                       input logic [4:0] wa, input logic [1:0] cls);
        rs_D = rs; rs_use_D = ru; tuse_rs_D = tr;
        rt_D = rt; rt_use_D = tu; tuse_rt_D = tt;
        wa_D = wa; wcls_D = cls;
        #1;
    endtask

    task automatic nop();
        ins(5'd0, 1'b0, 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b0;
        nop();
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        chk("rst_sel", 32'({f_rs_d, f_rt_d, f_rs_e, f_rt_e, f_rt_m}), 32'd0);
        reset = 1'b1;
        flush();

        // addu $3 ; addu $4,$3,$3
        ins(5'd1, 1, 2'd1, 5'd2, 1, 2'd1, 5'd3, 2'd1); tick();
        ins(5'd3, 1, 2'd1, 5'd3, 1, 2'd1, 5'd4, 2'd1);
        chk("alu_alu_stall", 32'(stall), 32'd0);
        tick(); nop();
        chk("alu_alu_rs_e", 32'(f_rs_e), 32'd2);
        chk("alu_alu_rt_e", 32'(f_rt_e), 32'd2);
        flush();

        // lw $5 ; addu $6,$5,$0
        ins(5'd29, 1, 2'd1, 5'd0, 0, 2'd0, 5'd5, 2'd2); tick();
        ins(5'd5, 1, 2'd1, 5'd0, 1, 2'd1, 5'd6, 2'd1);
        chk("ld_use_stall1", 32'(stall), 32'd1);
        tick();
        chk("ld_use_stall2", 32'(stall), 32'd0);
        tick(); nop();
        chk("ld_use_rs_e", 32'(f_rs_e), 32'd1);
        chk("ld_use_cnt", stall_cnt, 32'd1);
        flush();

        // addu $7 ; beq $7,$0
        ins(5'd1, 1, 2'd1, 5'd2, 1, 2'd1, 5'd7, 2'd1); tick();
        ins(5'd7, 1, 2'd0, 5'd0, 1, 2'd0, 5'd0, 2'd0);
        chk("br_alu_stall1", 32'(stall), 32'd1);
        tick();
        chk("br_alu_stall2", 32'(stall), 32'd0);
        chk("br_alu_rs_d", 32'(f_rs_d), 32'd2);
        flush();

        // lw $7 ; beq $7,$0
        ins(5'd29, 1, 2'd1, 5'd0, 0, 2'd0, 5'd7, 2'd2); tick();
        ins(5'd7, 1, 2'd0, 5'd0, 1, 2'd0, 5'd0, 2'd0);
        chk("br_ld_stall1", 32'(stall), 32'd1);
        tick();
        chk("br_ld_stall2", 32'(stall), 32'd1);
        chk("br_ld_rs_d_wait", 32'(f_rs_d), 32'd0);
        tick();
        chk("br_ld_stall3", 32'(stall), 32'd0);
        chk("br_ld_rs_d", 32'(f_rs_d), 32'd1);
        chk("br_ld_cnt", stall_cnt, 32'd4);
        flush();

        // lw $11 ; addu $12,$11,$11 -- double hazard costs one stall
        ins(5'd29, 1, 2'd1, 5'd0, 0, 2'd0, 5'd11, 2'd2); tick();
        ins(5'd11, 1, 2'd1, 5'd11, 1, 2'd1, 5'd12, 2'd1);
        chk("dbl_stall1", 32'(stall), 32'd1);
        tick();
        chk("dbl_stall2", 32'(stall), 32'd0);
        tick();
        chk("dbl_cnt", stall_cnt, 32'd5);
        flush();

        // jal ; jr $31
        ins(5'd0, 0, 2'd0, 5'd0, 0, 2'd0, 5'd31, 2'd3); tick();
        ins(5'd31, 1, 2'd0, 5'd0, 0, 2'd0, 5'd0, 2'd0);
        chk("jal_jr_stall", 32'(stall), 32'd0);
        chk("jal_jr_rs_d", 32'(f_rs_d), 32'd4);
        flush();

        // lw $0 ; user of $0 with tuse 0
        ins(5'd29, 1, 2'd1, 5'd0, 0, 2'd0, 5'd0, 2'd2); tick();
        ins(5'd0, 1, 2'd0, 5'd0, 1, 2'd0, 5'd10, 2'd1);
        chk("r0_stall", 32'(stall), 32'd0);
        chk("r0_sel_d", 32'({f_rs_d, f_rt_d}), 32'd0);
        tick(); nop();
        chk("r0_sel_e", 32'({f_rs_e, f_rt_e, f_rt_m}), 32'd0);
        flush();

        // addu $8 ; sw $8,0($29)
        ins(5'd1, 1, 2'd1, 5'd2, 1, 2'd1, 5'd8, 2'd1); tick();
        ins(5'd29, 1, 2'd1, 5'd8, 1, 2'd2, 5'd0, 2'd0);
        chk("st_alu_stall", 32'(stall), 32'd0);
        tick(); nop();
        chk("st_alu_rt_e", 32'(f_rt_e), 32'd2);
        flush();

        // lw $9 ; sw $9,0($29)
        ins(5'd29, 1, 2'd1, 5'd0, 0, 2'd0, 5'd9, 2'd2); tick();
        ins(5'd29, 1, 2'd1, 5'd9, 1, 2'd2, 5'd0, 2'd0);
        chk("st_ld_stall", 32'(stall), 32'd0);
        tick(); nop();
        chk("st_ld_rt_e", 32'(f_rt_e), 32'd0);
        tick();
        chk("st_ld_rt_m", 32'(f_rt_m), 32'd1);
        flush();

        // Reset during a load-use stall
        ins(5'd29, 1, 2'd1, 5'd0, 0, 2'd0, 5'd5, 2'd2); tick();
        ins(5'd5, 1, 2'd1, 5'd0, 1, 2'd1, 5'd6, 2'd1);
        chk("rst_mid_pre", 32'(stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_cnt", stall_cnt, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_rel_stall", 32'(stall), 32'd0);
        tick();
        chk("rst_rel_cnt", stall_cnt, 32'd0);
        chk("rst_rel_sel", 32'({f_rs_e, f_rt_e, f_rt_m}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
